// File: rtl/noc_switch_rr.sv
// ---------------------------------------------------------------------------
// noc_switch_rr
//
// Five-port network-on-chip switch with one FIFO per input and one registered
// output per port.  Each output runs its own round-robin arbiter over the
// FIFO heads that target it.  Port index and priority order is L=0, N=1, E=2,
// S=3, W=4.
//
// Parameters
//   DATA_W   flit data width in bits
//   DEPTH    per-input FIFO depth in flits (power of two, >= 2)
//
// Ports
//   clk                 single clock, rising edge
//   rst                 synchronous active-low reset
//   In_X                inbound flit data for input X
//   request_X           destination of inbound flit (0..4 = L..W, 7 = idle,
//                       5/6 illegal)
//   grant_X             combinational: the flit on input X is taken this edge
//   Out_X               registered outbound flit data for output X
//   out_valid_X         Out_X holds a valid flit
//   out_ready_X         downstream accepts Out_X at this edge
//   err_X               sticky flag: an illegal request code was seen on X
// ---------------------------------------------------------------------------
module noc_switch_rr #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] In_L,
    input  logic [DATA_W-1:0] In_N,
    input  logic [DATA_W-1:0] In_E,
    input  logic [DATA_W-1:0] In_S,
    input  logic [DATA_W-1:0] In_W,
    input  logic [2:0]        request_L,
    input  logic [2:0]        request_N,
    input  logic [2:0]        request_E,
    input  logic [2:0]        request_S,
    input  logic [2:0]        request_W,
    output logic              grant_L,
    output logic              grant_N,
    output logic              grant_E,
    output logic              grant_S,
    output logic              grant_W,
    output logic [DATA_W-1:0] Out_L,
    output logic [DATA_W-1:0] Out_N,
    output logic [DATA_W-1:0] Out_E,
    output logic [DATA_W-1:0] Out_S,
    output logic [DATA_W-1:0] Out_W,
    output logic              out_valid_L,
    output logic              out_valid_N,
    output logic              out_valid_E,
    output logic              out_valid_S,
    output logic              out_valid_W,
    input  logic              out_ready_L,
    input  logic              out_ready_N,
    input  logic              out_ready_E,
    input  logic              out_ready_S,
    input  logic              out_ready_W,
    output logic              err_L,
    output logic              err_N,
    output logic              err_E,
    output logic              err_S,
    output logic              err_W
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_W + 3;
    localparam int NPORTS  = 5;

    // Port-indexed views of the flat port list
    logic [DATA_W-1:0] in_data   [NPORTS];
    logic [2:0]        req       [NPORTS];
    logic [NPORTS-1:0] out_ready;

    assign in_data[0] = In_L;
    assign in_data[1] = In_N;
    assign in_data[2] = In_E;
    assign in_data[3] = In_S;
    assign in_data[4] = In_W;

    assign req[0] = request_L;
    assign req[1] = request_N;
    assign req[2] = request_E;
    assign req[3] = request_S;
    assign req[4] = request_W;

    assign out_ready = {out_ready_W, out_ready_S, out_ready_E, out_ready_N, out_ready_L};

    // State
    logic [ENTRY_W-1:0] mem_q      [NPORTS][DEPTH];
    logic [ENTRY_W-1:0] mem_d      [NPORTS][DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q   [NPORTS];
    logic [PTR_W-1:0]   wr_ptr_d   [NPORTS];
    logic [PTR_W-1:0]   rd_ptr_q   [NPORTS];
    logic [PTR_W-1:0]   rd_ptr_d   [NPORTS];
    logic [CNT_W-1:0]   count_q    [NPORTS];
    logic [CNT_W-1:0]   count_d    [NPORTS];
    logic [DATA_W-1:0]  out_data_q [NPORTS];
    logic [DATA_W-1:0]  out_data_d [NPORTS];
    logic [2:0]         rr_ptr_q   [NPORTS];
    logic [2:0]         rr_ptr_d   [NPORTS];
    logic [NPORTS-1:0]  out_valid_q;
    logic [NPORTS-1:0]  out_valid_d;
    logic [NPORTS-1:0]  err_q;
    logic [NPORTS-1:0]  err_d;

    // FIFO status, head decode and input acceptance
    logic [NPORTS-1:0]  fifo_full;
    logic [NPORTS-1:0]  fifo_empty;
    logic [NPORTS-1:0]  grant;
    logic [NPORTS-1:0]  illegal;
    logic [2:0]         head_dest  [NPORTS];
    logic [DATA_W-1:0]  head_data  [NPORTS];

    // Fullness is judged on the registered count only, so a full FIFO refuses
    // a write even when its head is being popped in the same cycle.
    always_comb begin
        fifo_full  = '0;
        fifo_empty = '0;
        grant      = '0;
        illegal    = '0;
        for (int i = 0; i < NPORTS; i++) begin
            head_dest[i]  = mem_q[i][rd_ptr_q[i]][ENTRY_W-1:DATA_W];
            head_data[i]  = mem_q[i][rd_ptr_q[i]][DATA_W-1:0];
            fifo_full[i]  = (count_q[i] == CNT_W'(DEPTH));
            fifo_empty[i] = (count_q[i] == '0);
            grant[i]      = rst && (req[i] <= 3'd4) && !fifo_full[i];
            illegal[i]    = rst && ((req[i] == 3'd5) || (req[i] == 3'd6));
        end
    end

    // Per-output round-robin search.  The scan starts at rr_ptr and wraps
    // modulo 5; the first non-empty head whose destination matches wins.
    // Each head has exactly one destination, so at most one output pops it.
    logic [NPORTS-1:0]  cand       [NPORTS];
    logic [NPORTS-1:0]  load_en;
    logic [NPORTS-1:0]  win_found;
    logic [2:0]         win_idx    [NPORTS];
    logic [NPORTS-1:0]  pop;
    logic [3:0]         scan;

    always_comb begin
        load_en   = '0;
        win_found = '0;
        pop       = '0;
        scan      = '0;
        for (int o = 0; o < NPORTS; o++) begin
            cand[o]    = '0;
            win_idx[o] = '0;
            load_en[o] = !out_valid_q[o] || out_ready[o];
            for (int i = 0; i < NPORTS; i++) begin
                cand[o][i] = !fifo_empty[i] && (head_dest[i] == 3'(o));
            end
            for (int k = 0; k < NPORTS; k++) begin
                scan = {1'b0, rr_ptr_q[o]} + 4'(k);
                if (scan >= 4'd5) begin
                    scan = scan - 4'd5;
                end
                if (!win_found[o] && cand[o][scan[2:0]]) begin
                    win_found[o] = 1'b1;
                    win_idx[o]   = scan[2:0];
                end
            end
            if (load_en[o] && win_found[o]) begin
                pop[win_idx[o]] = 1'b1;
            end
        end
    end

    // Next-state: FIFO writes/pops, output registers, arbiter pointers and
    // sticky error flags.  An output with room but no candidate drops valid
    // and keeps its last data.
    always_comb begin
        mem_d       = mem_q;
        out_valid_d = out_valid_q;
        err_d       = err_q | illegal;
        for (int i = 0; i < NPORTS; i++) begin
            wr_ptr_d[i]   = wr_ptr_q[i];
            rd_ptr_d[i]   = rd_ptr_q[i];
            count_d[i]    = count_q[i] + CNT_W'(grant[i]) - CNT_W'(pop[i]);
            out_data_d[i] = out_data_q[i];
            rr_ptr_d[i]   = rr_ptr_q[i];
            if (grant[i]) begin
                mem_d[i][wr_ptr_q[i]] = {req[i], in_data[i]};
                wr_ptr_d[i]           = wr_ptr_q[i] + 1'b1;
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
            end
        end
        for (int o = 0; o < NPORTS; o++) begin
            if (load_en[o]) begin
                if (win_found[o]) begin
                    out_data_d[o]  = head_data[win_idx[o]];
                    out_valid_d[o] = 1'b1;
                    rr_ptr_d[o]    = (win_idx[o] == 3'd4) ? 3'd0 : win_idx[o] + 3'd1;
                end else begin
                    out_valid_d[o] = 1'b0;
                end
            end
        end
    end

    // Control and output state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= '0;
            err_q       <= '0;
            for (int i = 0; i < NPORTS; i++) begin
                wr_ptr_q[i]   <= '0;
                rd_ptr_q[i]   <= '0;
                count_q[i]    <= '0;
                out_data_q[i] <= '0;
                rr_ptr_q[i]   <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            for (int i = 0; i < NPORTS; i++) begin
                wr_ptr_q[i]   <= wr_ptr_d[i];
                rd_ptr_q[i]   <= rd_ptr_d[i];
                count_q[i]    <= count_d[i];
                out_data_q[i] <= out_data_d[i];
                rr_ptr_q[i]   <= rr_ptr_d[i];
            end
        end
    end

    // FIFO storage needs no reset: occupancy is governed by the counters,
    // and no write can happen while rst is low because grant is gated.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign grant_L = grant[0];
    assign grant_N = grant[1];
    assign grant_E = grant[2];
    assign grant_S = grant[3];
    assign grant_W = grant[4];

    assign Out_L = out_data_q[0];
    assign Out_N = out_data_q[1];
    assign Out_E = out_data_q[2];
    assign Out_S = out_data_q[3];
    assign Out_W = out_data_q[4];

    assign out_valid_L = out_valid_q[0];
    assign out_valid_N = out_valid_q[1];
    assign out_valid_E = out_valid_q[2];
    assign out_valid_S = out_valid_q[3];
    assign out_valid_W = out_valid_q[4];

    assign err_L = err_q[0];
    assign err_N = err_q[1];
    assign err_E = err_q[2];
    assign err_S = err_q[3];
    assign err_W = err_q[4];

endmodule

// File: tb/tb_noc_switch_rr.sv
// ---------------------------------------------------------------------------
// tb_noc_switch_rr
//
// Directed scenarios followed by randomized traffic for noc_switch_rr, all
// compared against a queue-based reference model of the switch.
// ---------------------------------------------------------------------------
module tb_noc_switch_rr;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;

   logic clk;
   logic rst;
   logic [DATA_W-1:0] inData [5];
   logic [2:0] req [5];
   logic ready [5];

   logic [DATA_W-1:0] outObs [5];
   logic validObs [5];
   logic grantObs [5];
   logic errObs [5];
   logic lastGrant [5];

   int passed = 0;
   int total = 0;

   // Reference model state: one queue of {dest, data} per input
   logic [DATA_W+2:0] mQ [5][$];
   logic [DATA_W-1:0] mOut [5];
   logic mValid [5];
   logic mErr [5];
   logic mGrant [5];
   int mPtr [5];

   noc_switch_rr #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .In_L(inData[0]), .In_N(inData[1]), .In_E(inData[2]), .In_S(inData[3]), .In_W(inData[4]),
      .request_L(req[0]), .request_N(req[1]), .request_E(req[2]), .request_S(req[3]), .request_W(req[4]),
      .grant_L(grantObs[0]), .grant_N(grantObs[1]), .grant_E(grantObs[2]), .grant_S(grantObs[3]), .grant_W(grantObs[4]),
      .Out_L(outObs[0]), .Out_N(outObs[1]), .Out_E(outObs[2]), .Out_S(outObs[3]), .Out_W(outObs[4]),
      .out_valid_L(validObs[0]), .out_valid_N(validObs[1]), .out_valid_E(validObs[2]),
      .out_valid_S(validObs[3]), .out_valid_W(validObs[4]),
      .out_ready_L(ready[0]), .out_ready_N(ready[1]), .out_ready_E(ready[2]),
      .out_ready_S(ready[3]), .out_ready_W(ready[4]),
      .err_L(errObs[0]), .err_N(errObs[1]), .err_E(errObs[2]), .err_S(errObs[3]), .err_W(errObs[4])
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always terminates
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end else begin
         passed++;
      end
   endtask

   // Acceptance rule: legal destination, room in the queue, not in reset
   function automatic void modelGrants();
      for (int i = 0; i < 5; i++) begin
         mGrant[i] = rst && (req[i] <= 3'd4) && (mQ[i].size() < DEPTH);
      end
   endfunction

   // Model of one rising edge, using the inputs held across that edge
   function automatic void modelEdge();
      logic doPop [5];
      if (!rst) begin
         for (int i = 0; i < 5; i++) begin
            mQ[i].delete();
            mOut[i] = '0;
            mValid[i] = 1'b0;
            mErr[i] = 1'b0;
            mPtr[i] = 0;
         end
         return;
      end
      for (int i = 0; i < 5; i++) doPop[i] = 1'b0;
      for (int o = 0; o < 5; o++) begin
         if (!mValid[o] || ready[o]) begin
            int winner = -1;
            for (int k = 0; k < 5; k++) begin
               int idx = (mPtr[o] + k) % 5;
               if (winner < 0 && mQ[idx].size() > 0 && int'(mQ[idx][0][DATA_W+2:DATA_W]) == o)
                  winner = idx;
            end
            if (winner >= 0) begin
               mOut[o] = mQ[winner][0][DATA_W-1:0];
               mValid[o] = 1'b1;
               mPtr[o] = (winner + 1) % 5;
               doPop[winner] = 1'b1;
            end else begin
               mValid[o] = 1'b0;
            end
         end
      end
      for (int i = 0; i < 5; i++) begin
         if (doPop[i]) void'(mQ[i].pop_front());
         if (mGrant[i]) mQ[i].push_back({req[i], inData[i]});
         if (req[i] == 3'd5 || req[i] == 3'd6) mErr[i] = 1'b1;
      end
   endfunction

   // One clock cycle with the currently driven inputs: check grants before
   // the edge, advance the model at the edge, check registered outputs after
   task automatic applyStimulus();
      #1;
      modelGrants();
      for (int i = 0; i < 5; i++) begin
         lastGrant[i] = grantObs[i];
         checkOutput($sformatf("grant[%0d]", i), 32'(grantObs[i]), 32'(mGrant[i]));
      end
      @(posedge clk);
      modelEdge();
      #1;
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("out[%0d]", i), 32'(outObs[i]), 32'(mOut[i]));
         checkOutput($sformatf("valid[%0d]", i), 32'(validObs[i]), 32'(mValid[i]));
         checkOutput($sformatf("err[%0d]", i), 32'(errObs[i]), 32'(mErr[i]));
      end
   endtask

   task automatic setIdle();
      for (int i = 0; i < 5; i++) begin
         req[i] = 3'd7;
         inData[i] = '0;
      end
   endtask

   task automatic doReset(input int edges);
      setIdle();
      rst = 1'b0;
      repeat (edges) applyStimulus();
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ready[i] = 1'b1;
         mOut[i] = '0;
         mValid[i] = 1'b0;
         mErr[i] = 1'b0;
         mPtr[i] = 0;
      end
      setIdle();
      @(negedge clk);

      // Reset for two edges with all inputs idle
      doReset(2);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("rst_out[%0d]", i), 32'(outObs[i]), 32'd0);
         checkOutput($sformatf("rst_valid[%0d]", i), 32'(validObs[i]), 32'd0);
      end

      // Single flit W -> L
      req[4] = 3'd0; inData[4] = 8'd5;
      applyStimulus();
      checkOutput("single_grant_W", 32'(lastGrant[4]), 32'd1);
      setIdle();
      applyStimulus();
      checkOutput("single_out_L", 32'(outObs[0]), 32'd5);
      checkOutput("single_valid_L", 32'(validObs[0]), 32'd1);
      applyStimulus();
      checkOutput("single_valid_L_drop", 32'(validObs[0]), 32'd0);

      // Contention N, S, W -> E
      doReset(1);
      req[1] = 3'd2; inData[1] = 8'd2;
      req[3] = 3'd2; inData[3] = 8'd5;
      req[4] = 3'd2; inData[4] = 8'd4;
      applyStimulus();
      setIdle();
      applyStimulus();
      checkOutput("cont_first", 32'(outObs[2]), 32'd2);
      applyStimulus();
      checkOutput("cont_second", 32'(outObs[2]), 32'd5);
      applyStimulus();
      checkOutput("cont_third", 32'(outObs[2]), 32'd4);
      checkOutput("cont_ptr_E", 32'(mPtr[2]), 32'd0);

      // Backpressure on E with L streaming six flits
      doReset(1);
      ready[2] = 1'b0;
      for (int f = 1; f <= 6; f++) begin
         req[0] = 3'd2; inData[0] = 8'(f);
         applyStimulus();
         checkOutput($sformatf("bp_grant_%0d", f), 32'(lastGrant[0]), (f <= 5) ? 32'd1 : 32'd0);
      end
      setIdle();
      checkOutput("bp_hold", 32'(outObs[2]), 32'd1);
      ready[2] = 1'b1;
      for (int f = 2; f <= 5; f++) begin
         applyStimulus();
         checkOutput($sformatf("bp_drain_%0d", f), 32'(outObs[2]), 32'(f));
      end

      // Illegal request code on N
      doReset(1);
      req[1] = 3'd5; inData[1] = 8'hAA;
      applyStimulus();
      checkOutput("illegal_grant_N", 32'(lastGrant[1]), 32'd0);
      checkOutput("illegal_err_N", 32'(errObs[1]), 32'd1);
      setIdle();
      applyStimulus();
      checkOutput("illegal_no_valid", 32'(validObs[0] | validObs[1] | validObs[2] | validObs[3] | validObs[4]), 32'd0);

      // Reset in the middle of buffered traffic toward E
      doReset(1);
      ready[2] = 1'b0;
      for (int f = 0; f < 3; f++) begin
         req[0] = 3'd2; inData[0] = 8'(8'h10 + f);
         applyStimulus();
      end
      doReset(1);
      ready[2] = 1'b1;
      for (int c = 0; c < 4; c++) begin
         applyStimulus();
         checkOutput($sformatf("midrst_valid_E_%0d", c), 32'(validObs[2]), 32'd0);
      end

      // Randomized traffic, backpressure and occasional resets
      for (int c = 0; c < 800; c++) begin
         rst = ($urandom_range(0, 99) != 0);
         for (int i = 0; i < 5; i++) begin
            int r = int'($urandom_range(0, 39));
            if (r < 26) req[i] = 3'(r % 5);
            else if (r < 39) req[i] = 3'd7;
            else req[i] = ($urandom_range(0, 1) != 0) ? 3'd5 : 3'd6;
            inData[i] = 8'($urandom);
            ready[i] = ($urandom_range(0, 3) != 0);
         end
         applyStimulus();
      end
      rst = 1'b1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/noc_switch_rr.md
NOC_SWITCH_RR -- requirements
Module: noc_switch_rr

Interface
REQ-001 Parameter DATA_W, default 8: flit data width in bits.
REQ-002 Parameter DEPTH, default 4: per-input FIFO depth in flits; a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low: sampled low on a rising clk edge, it resets the block.
REQ-005 In_L, In_N, In_E, In_S, In_W  input  DATA_W each  inbound flit data per port.
REQ-006 request_L, request_N, request_E, request_S, request_W  input  3 each  destination of the inbound flit: 0=L, 1=N, 2=E, 3=S, 4=W, 7=idle; codes 5 and 6 are illegal.
REQ-007 grant_L, grant_N, grant_E, grant_S, grant_W  output  1 each  flit on that input is accepted at this rising edge.
REQ-008 Out_L, Out_N, Out_E, Out_S, Out_W  output  DATA_W each  outbound flit data, registered.
REQ-009 out_valid_L, out_valid_N, out_valid_E, out_valid_S, out_valid_W  output  1 each  Out_X holds a valid flit.
REQ-010 out_ready_L, out_ready_N, out_ready_E, out_ready_S, out_ready_W  input  1 each  downstream accepts Out_X at this edge.
REQ-011 err_L, err_N, err_E, err_S, err_W  output  1 each  sticky flag: an illegal request code was seen on that input.

Function
REQ-012 Port index and priority order SHALL be L=0, N=1, E=2, S=3, W=4.
REQ-013 Each input SHALL own a FIFO of DEPTH entries storing {dest[2:0], data}.
REQ-014 grant_X SHALL be combinational: request_X in 0..4 AND FIFO_X not full AND rst high.
REQ-015 A flit SHALL be written into FIFO_X exactly when grant_X=1; request 7, 5 or 6 writes nothing.
REQ-016 Illegal codes 5 or 6 SHALL set err_X at the next edge; err_X stays 1 until reset.
REQ-017 A full FIFO SHALL refuse writes (grant_X=0) even if it is popped in the same cycle.
REQ-018 Push and pop in the same cycle on a non-full, non-empty FIFO SHALL leave occupancy unchanged.
REQ-019 Output register O SHALL be loadable when out_valid_O=0 or out_ready_O=1.
REQ-020 Per output O, a round-robin arbiter SHALL choose among non-empty FIFO heads whose dest=O, searching upward from pointer ptr_O, modulo 5.
REQ-021 On a load, the winner's head SHALL be popped and written to Out_O, out_valid_O set to 1, and ptr_O set to (winner+1) mod 5.
REQ-022 ptr_O SHALL NOT change on a cycle with no grant to O.
REQ-023 If O is loadable and has no candidate, out_valid_O SHALL go to 0 and Out_O SHALL hold its last value.
REQ-024 If out_valid_O=1 and out_ready_O=0, Out_O and out_valid_O SHALL hold.
REQ-025 A FIFO head targets exactly one output, so it is never popped twice in one cycle.
REQ-026 U-turn (dest equal to the own port) SHALL be legal and routed like any other destination.
REQ-027 Latency: a flit accepted at edge t, uncontended and with the output loadable, SHALL appear on Out_O with out_valid_O=1 after edge t+1.
REQ-028 Flits from one input to one output SHALL leave in acceptance order.

Reset
REQ-029 On rst=0 at an edge: all FIFOs empty; all ptr_O=0; Out_X=0; out_valid_X=0; err_X=0.
REQ-030 While rst=0, all grant_X SHALL be 0 and inputs SHALL be ignored.
REQ-031 Reset mid-operation SHALL discard all buffered and registered flits; none SHALL appear after rst returns high.

Verification (DATA_W=8, DEPTH=4)
REQ-032 Reset: rst=0 for 2 edges, all requests=7 -> all Out=0, out_valid=0, grant=0, err=0.
REQ-033 Single flit: request_W=0, In_W=5 for one cycle, out_ready_L=1 -> grant_W=1; after the next edge Out_L=5, out_valid_L=1 for exactly one cycle.
REQ-034 Contention: request_N=request_S=request_W=2 with In=2/5/4 for one cycle, out_ready_E=1 -> Out_E sequence 2, 5, 4 on consecutive cycles; ptr_E ends at 0.
REQ-035 Backpressure: out_ready_E=0, request_L=2, In_L=1..6 over 6 cycles -> flits 1-5 granted, flit 6 refused (grant_L=0), Out_E holds 1; then out_ready_E=1 -> Out_E 1, 2, 3, 4, 5 on consecutive cycles.
REQ-036 Illegal code: request_N=5 for one cycle -> grant_N=0, err_N=1 after the edge, no output valid.
REQ-037 Mid-operation reset: 3 flits buffered for E with out_ready_E=0, rst=0 for one edge, then out_ready_E=1 -> out_valid_E stays 0.
